// File: rtl/fp_pix_pkg.sv
// Shared types and constants for the float-to-pixel conversion path.
package fp_pix_pkg;

  localparam int FP_EXP_W   = 8;
  localparam int FP_MAN_W   = 23;
  localparam int FP_BIAS    = 127;
  localparam int EXP_CALC_W = 10;
  localparam int SHAMT_W    = 5;
  // Widest round/clamp intermediate (OUT_W max 16, plus 2 bits).
  localparam int G_MAX_W    = 18;

  typedef enum logic [2:0] {
    FPC_NORM = 3'd0,
    FPC_ZERO = 3'd1,
    FPC_NAN  = 3'd2,
    FPC_PINF = 3'd3,
    FPC_NINF = 3'd4,
    FPC_NEG  = 3'd5
  } fp_class_t;

  // S1 -> S2: class plus the mantissa and the shift that aligns it.
  typedef struct packed {
    fp_class_t              cls;
    logic [SHAMT_W-1:0]     shamt;
    logic [FP_MAN_W:0]      mant;
  } s1_t;

  // S2 -> S3: class plus the doubled, truncated magnitude.
  typedef struct packed {
    fp_class_t              cls;
    logic [G_MAX_W-1:0]     g;
  } s2_t;

  // Classify the raw fields; range-dependent classes are decided later.
  function automatic fp_class_t fp_classify(input logic sign_f,
                                            input logic [FP_EXP_W-1:0] exp_f,
                                            input logic [FP_MAN_W-1:0] man_f);
    fp_class_t cls;
    if (exp_f == 8'hFF) begin
      if (man_f != 23'd0) begin
        cls = FPC_NAN;
      end else if (sign_f) begin
        cls = FPC_NINF;
      end else begin
        cls = FPC_PINF;
      end
    end else if (exp_f == 8'h00) begin
      cls = FPC_ZERO;
    end else if (sign_f) begin
      cls = FPC_NEG;
    end else begin
      cls = FPC_NORM;
    end
    return cls;
  endfunction

endpackage

// File: rtl/fp_pix_round_sat.sv
// Combinational round-half-up and clamp of a doubled magnitude to OUT_W bits.
module fp_pix_round_sat
  import fp_pix_pkg::*;
#(
  parameter int OUT_W = 8
) (
  input  fp_class_t          cls_i,
  input  logic [G_MAX_W-1:0] g_i,
  output logic [OUT_W-1:0]   data_o,
  output logic               sat_o
);

  localparam logic [G_MAX_W-1:0] ONE_G = {{(G_MAX_W-1){1'b0}}, 1'b1};
  localparam logic [G_MAX_W-1:0] MAX_G = (ONE_G << OUT_W) - ONE_G;
  localparam logic [OUT_W-1:0]   MAX_D = {OUT_W{1'b1}};

  logic [G_MAX_W-1:0] r_s;

  // g holds value*2; adding one then halving rounds ties up. g < 2^(OUT_W+1), so no wrap.
  assign r_s = (g_i + ONE_G) >> 5'd1;

  // Map class and rounded magnitude to pixel value and saturation flag.
  always_comb begin
    data_o = {OUT_W{1'b0}};
    sat_o  = 1'b1;
    case (cls_i)
      FPC_NORM: begin
        if (r_s > MAX_G) begin
          data_o = MAX_D;
          sat_o  = 1'b1;
        end else begin
          data_o = r_s[OUT_W-1:0];
          sat_o  = 1'b0;
        end
      end
      FPC_ZERO: begin
        data_o = {OUT_W{1'b0}};
        sat_o  = 1'b0;
      end
      FPC_PINF: begin
        data_o = MAX_D;
        sat_o  = 1'b1;
      end
      FPC_NAN, FPC_NINF, FPC_NEG: begin
        data_o = {OUT_W{1'b0}};
        sat_o  = 1'b1;
      end
      default: begin
        data_o = {OUT_W{1'b0}};
        sat_o  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/fp_to_pixel.sv
// Three-stage IEEE-754 single to saturated unsigned pixel converter with
// global-enable flow control and a saturating count of flagged samples.
module fp_to_pixel
  import fp_pix_pkg::*;
#(
  parameter int OUT_W       = 8,
  parameter int SCALE_SHIFT = 0,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             snk_valid,
  input  logic [31:0]      snk_data,
  output logic             snk_ready,
  output logic             src_valid,
  output logic [OUT_W-1:0] src_data,
  output logic             src_sat,
  input  logic             src_ready,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] sat_count
);

  localparam logic signed [EXP_CALC_W-1:0] BIAS_E  = 10'sd127;
  localparam logic signed [EXP_CALC_W-1:0] SCALE_E = EXP_CALC_W'(SCALE_SHIFT);
  localparam logic signed [EXP_CALC_W-1:0] OUTW_E  = EXP_CALC_W'(OUT_W);
  localparam logic [CNT_W-1:0]             CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]             CNT_MAX = {CNT_W{1'b1}};

  logic                          en_s;
  logic signed [EXP_CALC_W-1:0]  exp_unb_s;
  fp_class_t                     base_cls_s;
  s1_t                           s1_d, s1_q;
  s2_t                           s2_d, s2_q;
  logic                          s1_vld_q, s2_vld_q;
  logic                          src_valid_q, src_sat_q;
  logic [OUT_W-1:0]              src_data_q;
  logic [OUT_W-1:0]              rs_data_s;
  logic                          rs_sat_s;
  logic [CNT_W-1:0]              sat_cnt_d, sat_cnt_q;

  // Whole pipeline advances whenever the output register is free or draining.
  assign en_s      = src_ready || !src_valid_q;
  assign snk_ready = en_s;
  assign src_valid = src_valid_q;
  assign src_data  = src_data_q;
  assign src_sat   = src_sat_q;
  assign sat_count = sat_cnt_q;

  assign base_cls_s = fp_classify(snk_data[31], snk_data[30:23], snk_data[22:0]);
  assign exp_unb_s  = $signed({2'b00, snk_data[30:23]}) - BIAS_E + SCALE_E;

  // S1: fold the range checks into the class so S3 needs no exponent.
  always_comb begin
    s1_d.mant  = {1'b1, snk_data[22:0]};
    s1_d.shamt = 5'd22 - exp_unb_s[SHAMT_W-1:0];
    s1_d.cls   = base_cls_s;
    if (base_cls_s == FPC_NORM) begin
      if (exp_unb_s >= OUTW_E) begin
        s1_d.cls = FPC_PINF;
      end else if (exp_unb_s < -10'sd1) begin
        s1_d.cls = FPC_ZERO;
      end else begin
        s1_d.cls = FPC_NORM;
      end
    end else begin
      s1_d.cls = base_cls_s;
    end
  end

  // S2: barrel shift to value*2 (shift 23 down to 23-OUT_W for in-range normals).
  always_comb begin
    s2_d.cls = s1_q.cls;
    if (s1_q.cls == FPC_NORM) begin
      s2_d.g = G_MAX_W'(s1_q.mant >> s1_q.shamt);
    end else begin
      s2_d.g = {G_MAX_W{1'b0}};
    end
  end

  fp_pix_round_sat #(
    .OUT_W (OUT_W)
  ) u_round_sat (
    .cls_i  (s2_q.cls),
    .g_i    (s2_q.g),
    .data_o (rs_data_s),
    .sat_o  (rs_sat_s)
  );

  // Stage registers: all advance together on enable, all hold otherwise.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_vld_q    <= 1'b0;
      s2_vld_q    <= 1'b0;
      s1_q        <= '0;
      s2_q        <= '0;
      src_valid_q <= 1'b0;
      src_data_q  <= {OUT_W{1'b0}};
      src_sat_q   <= 1'b0;
    end else if (en_s) begin
      s1_vld_q    <= snk_valid;
      s2_vld_q    <= s1_vld_q;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      src_valid_q <= s2_vld_q;
      if (s2_vld_q) begin
        src_data_q <= rs_data_s;
        src_sat_q  <= rs_sat_s;
      end else begin
        src_data_q <= src_data_q;
        src_sat_q  <= src_sat_q;
      end
    end else begin
      s1_vld_q    <= s1_vld_q;
      s2_vld_q    <= s2_vld_q;
      s1_q        <= s1_q;
      s2_q        <= s2_q;
      src_valid_q <= src_valid_q;
      src_data_q  <= src_data_q;
      src_sat_q   <= src_sat_q;
    end
  end

  // Saturation counter next state: clear wins over a flagged handshake.
  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (cnt_clr) begin
      sat_cnt_d = {CNT_W{1'b0}};
    end else if (src_valid_q && src_ready && src_sat_q && (sat_cnt_q != CNT_MAX)) begin
      sat_cnt_d = sat_cnt_q + CNT_ONE;
    end else begin
      sat_cnt_d = sat_cnt_q;
    end
  end

  // Saturation counter register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sat_cnt_q <= {CNT_W{1'b0}};
    end else begin
      sat_cnt_q <= sat_cnt_d;
    end
  end

endmodule

// File: tb/tb_fp_to_pixel.sv
// Self-checking bench for fp_to_pixel: vector table, random backpressure
// stream, scaling, counter and mid-stream reset sequences.
module tb_fp_to_pixel;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;

  // Instance A: OUT_W=8, SCALE_SHIFT=0, CNT_W=4
  logic        a_snk_valid;
  logic [31:0] a_snk_data;
  logic        a_snk_ready;
  logic        a_src_valid;
  logic [7:0]  a_src_data;
  logic        a_src_sat;
  logic        a_src_ready;
  logic        a_cnt_clr;
  logic [3:0]  a_sat_count;

  // Instance B: OUT_W=8, SCALE_SHIFT=8, CNT_W=16
  logic        b_snk_valid;
  logic [31:0] b_snk_data;
  logic        b_snk_ready;
  logic        b_src_valid;
  logic [7:0]  b_src_data;
  logic        b_src_sat;
  logic        b_src_ready;
  logic        b_cnt_clr;
  logic [15:0] b_sat_count;

  fp_to_pixel #(.OUT_W(8), .SCALE_SHIFT(0), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst),
    .snk_valid(a_snk_valid), .snk_data(a_snk_data), .snk_ready(a_snk_ready),
    .src_valid(a_src_valid), .src_data(a_src_data), .src_sat(a_src_sat),
    .src_ready(a_src_ready), .cnt_clr(a_cnt_clr), .sat_count(a_sat_count)
  );

  fp_to_pixel #(.OUT_W(8), .SCALE_SHIFT(8), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst),
    .snk_valid(b_snk_valid), .snk_data(b_snk_data), .snk_ready(b_snk_ready),
    .src_valid(b_src_valid), .src_data(b_src_data), .src_sat(b_src_sat),
    .src_ready(b_src_ready), .cnt_clr(b_cnt_clr), .sat_count(b_sat_count)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit mon_on = 1'b0;

  typedef struct {
    int data;
    int sat;
    int acc_cyc;
    bit lat;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [31:0] f;
    int          d;
    int          s;
  } vec_t;
  vec_t vecs[14];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Reference conversion using real arithmetic.
  function automatic void model(input logic [31:0] f, input int out_w, input int ss,
                                output int d, output int sat);
    int          e;
    int          ex;
    int          mx;
    logic [22:0] m;
    real         v;
    e  = int'(f[30:23]);
    m  = f[22:0];
    mx = (1 << out_w) - 1;
    if (e == 255 && m != 23'd0) begin
      d = 0; sat = 1;
    end else if (e == 255) begin
      d = f[31] ? 0 : mx; sat = 1;
    end else if (e == 0) begin
      d = 0; sat = 0;
    end else if (f[31]) begin
      d = 0; sat = 1;
    end else begin
      ex = e - 127 + ss;
      if (ex >= out_w) begin
        d = mx; sat = 1;
      end else if (ex < -1) begin
        d = 0; sat = 0;
      end else begin
        v = 1.0 + real'(m) / 8388608.0;
        for (int k = 0; k < ex; k++) v = v * 2.0;
        if (ex < 0) v = v / 2.0;
        d = $rtoi(v + 0.5);
        if (d > mx) begin
          d = mx; sat = 1;
        end else begin
          sat = 0;
        end
      end
    end
  endfunction

  function automatic logic [31:0] rand_float();
    logic [31:0] specials [7];
    logic [31:0] f;
    specials[0] = 32'h7F800000; specials[1] = 32'hFF800000;
    specials[2] = 32'h7FC00001; specials[3] = 32'h00000000;
    specials[4] = 32'h80000001; specials[5] = 32'hBF000000;
    specials[6] = 32'h437F8000;
    if ($urandom_range(0, 9) < 7) begin
      f[31]    = 1'b0;
      f[30:23] = 8'($urandom_range(118, 136));
      f[22:0]  = 23'($urandom);
      if ($urandom_range(0, 3) == 0) f[14:0] = 15'd0;
    end else begin
      f = specials[$urandom_range(0, 6)];
    end
    return f;
  endfunction

  // Present one sample to instance A, push its expectation when accepted.
  task automatic send_a(input logic [31:0] f, input int ed, input int es, input bit lat);
    int   guard;
    exp_t x;
    guard = 0;
    a_snk_valid = 1'b1;
    a_snk_data  = f;
    @(negedge clk);
    while (!a_snk_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (a_snk_ready) begin
      x.data = ed; x.sat = es; x.acc_cyc = cyc; x.lat = lat;
      sb.push_back(x);
    end else begin
      chk("accept_timeout", 0, 1);
    end
    @(posedge clk); #1;
    a_snk_valid = 1'b0;
  endtask

  task automatic drain_a(input int limit);
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < limit) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  // Output monitor for instance A: scoreboard, hold stability, counter model.
  initial begin
    exp_t x;
    bit   hold_pend;
    int   hold_data;
    int   hold_sat;
    int   cnt_m;
    hold_pend = 1'b0; hold_data = 0; hold_sat = 0; cnt_m = 0;
    wait (mon_on);
    forever begin
      @(negedge clk);
      if (hold_pend) begin
        chk("hold_valid", int'(a_src_valid), 1);
        chk("hold_data", int'(a_src_data), hold_data);
        chk("hold_sat", int'(a_src_sat), hold_sat);
      end
      hold_pend = rst && a_src_valid && !a_src_ready;
      hold_data = int'(a_src_data);
      hold_sat  = int'(a_src_sat);
      if (a_src_valid && a_src_ready) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_output: got data %0d sat %0d, expected none", a_src_data, a_src_sat);
        end else begin
          x = sb.pop_front();
          chk("out_data", int'(a_src_data), x.data);
          chk("out_sat", int'(a_src_sat), x.sat);
          if (x.lat) chk("latency", cyc - x.acc_cyc, 3);
        end
      end
      chk("sat_count", int'(a_sat_count), cnt_m);
      if (!rst) cnt_m = 0;
      else if (a_cnt_clr) cnt_m = 0;
      else if (a_src_valid && a_src_ready && a_src_sat && cnt_m != 15) cnt_m++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ed, es, n_acc, guard, seen;
    bit accepted;
    exp_t x;

    vecs[0]  = '{32'h42C80000, 100, 0};
    vecs[1]  = '{32'h42C90000, 101, 0};
    vecs[2]  = '{32'h3F000000, 1,   0};
    vecs[3]  = '{32'h3EFFFFFF, 0,   0};
    vecs[4]  = '{32'h437F0000, 255, 0};
    vecs[5]  = '{32'h3FC00000, 2,   0};
    vecs[6]  = '{32'h40200000, 3,   0};
    vecs[7]  = '{32'h437F8000, 255, 1};
    vecs[8]  = '{32'h7F800000, 255, 1};
    vecs[9]  = '{32'hBF800000, 0,   1};
    vecs[10] = '{32'h7FC00000, 0,   1};
    vecs[11] = '{32'h80000000, 0,   0};
    vecs[12] = '{32'h00000001, 0,   0};
    vecs[13] = '{32'hFF800000, 0,   1};

    rst = 1'b0;
    a_snk_valid = 1'b0; a_snk_data = 32'd0; a_src_ready = 1'b0; a_cnt_clr = 1'b0;
    b_snk_valid = 1'b0; b_snk_data = 32'd0; b_src_ready = 1'b1; b_cnt_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_src_valid", int'(a_src_valid), 0);
    chk("rst_src_data", int'(a_src_data), 0);
    chk("rst_src_sat", int'(a_src_sat), 0);
    chk("rst_snk_ready", int'(a_snk_ready), 1);
    chk("rst_sat_count", int'(a_sat_count), 0);
    mon_on = 1'b1;
    @(posedge clk); #1;

    // Table vectors back to back with the output always ready.
    a_src_ready = 1'b1;
    for (int i = 0; i < 14; i++) send_a(vecs[i].f, vecs[i].d, vecs[i].s, 1'b1);
    drain_a(50);

    // Random stream with random valid gaps and random downstream stalls.
    n_acc = 0; guard = 0;
    while (n_acc < 20 && guard < 2000) begin
      a_src_ready = ($urandom_range(0, 3) != 0);
      if (!a_snk_valid && $urandom_range(0, 2) != 0) begin
        a_snk_data  = rand_float();
        a_snk_valid = 1'b1;
      end
      @(negedge clk);
      accepted = a_snk_valid && a_snk_ready;
      if (accepted) begin
        model(a_snk_data, 8, 0, ed, es);
        x.data = ed; x.sat = es; x.acc_cyc = cyc; x.lat = 1'b0;
        sb.push_back(x);
        n_acc++;
      end
      @(posedge clk); #1;
      if (accepted) a_snk_valid = 1'b0;
      guard++;
    end
    chk("random_accepted", n_acc, 20);
    guard = 0;
    while (sb.size() != 0 && guard < 500) begin
      a_src_ready = ($urandom_range(0, 1) != 0);
      @(posedge clk); #1;
      guard++;
    end
    chk("random_drain", sb.size(), 0);
    a_src_ready = 1'b1;

    // Scaling on instance B: 0.5 -> 128, 1.0 -> 255 saturated.
    b_snk_valid = 1'b1; b_snk_data = 32'h3F000000;
    @(negedge clk);
    chk("b_snk_ready", int'(b_snk_ready), 1);
    @(posedge clk); #1 b_snk_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("b_half_valid", int'(b_src_valid), 1);
    chk("b_half_data", int'(b_src_data), 128);
    chk("b_half_sat", int'(b_src_sat), 0);
    @(posedge clk); #1;
    b_snk_valid = 1'b1; b_snk_data = 32'h3F800000;
    @(posedge clk); #1 b_snk_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("b_one_valid", int'(b_src_valid), 1);
    chk("b_one_data", int'(b_src_data), 255);
    chk("b_one_sat", int'(b_src_sat), 1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("b_sat_count", int'(b_sat_count), 1);
    @(posedge clk); #1;

    // Counter saturates at 15 with CNT_W=4 after 17 flagged samples.
    a_cnt_clr = 1'b1;
    @(posedge clk); #1 a_cnt_clr = 1'b0;
    for (int i = 0; i < 17; i++) send_a(32'h7F800000, 255, 1, 1'b0);
    drain_a(50);
    @(negedge clk);
    chk("cnt_hold_15", int'(a_sat_count), 15);
    @(posedge clk); #1;

    // Clear in the same cycle as a flagged handshake.
    a_src_ready = 1'b0;
    send_a(32'h7F800000, 255, 1, 1'b0);
    guard = 0;
    @(negedge clk);
    while (!a_src_valid && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("stall_out_valid", int'(a_src_valid), 1);
    @(posedge clk); #1;
    a_src_ready = 1'b1; a_cnt_clr = 1'b1;
    @(posedge clk); #1 a_cnt_clr = 1'b0;
    @(negedge clk);
    chk("clr_wins", int'(a_sat_count), 0);
    @(posedge clk); #1;
    send_a(32'hBF800000, 0, 1, 1'b1);
    drain_a(50);
    @(negedge clk);
    chk("cnt_after_clr", int'(a_sat_count), 1);
    @(posedge clk); #1;

    // Reset with three samples in flight behind a stalled output.
    a_src_ready = 1'b0;
    send_a(32'h42C80000, 100, 0, 1'b0);
    send_a(32'h437F8000, 255, 1, 1'b0);
    send_a(32'h3F000000, 1, 0, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("mid_rst_valid", int'(a_src_valid), 0);
    chk("mid_rst_snk_ready", int'(a_snk_ready), 1);
    chk("mid_rst_count", int'(a_sat_count), 0);
    chk("mid_rst_data", int'(a_src_data), 0);
    @(posedge clk); #1;
    a_src_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (a_src_valid) seen++;
    end
    chk("no_stale_output", seen, 0);
    @(posedge clk); #1;
    send_a(32'h3F000000, 1, 0, 1'b1);
    drain_a(50);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_to_pixel.md
# fp_to_pixel

Pipelined converter that consumes the IEEE-754 single-precision quotient stream from the floating-point divider wrapper and produces unsigned saturated pixel components for the background-reconstruction video path. Sits directly downstream of the divider: its sink port attaches to the divider's `src_valid`/`src_ready`/`src_data`. Applies power-of-two scaling, rounds half-up and clamps. Flags and counts every out-of-range sample.

## Interface
- `OUT_W`, default 8: output pixel width, legal 1..16.
- `SCALE_SHIFT`, default 0: signed power-of-two scale added to the exponent; value converted is `v * 2^SCALE_SHIFT`.
- `CNT_W`, default 16: saturation counter width.

Ports:
- `clk` in 1: clock. All logic is on the rising edge.
- `rst` in 1: reset. Synchronous, active-low.
- `snk_valid` in 1: input float valid.
- `snk_data` in 32: IEEE-754 single.
- `snk_ready` out 1: input accepted when `snk_valid && snk_ready`.
- `src_valid` out 1: output valid.
- `src_data` out OUT_W: converted pixel.
- `src_sat` out 1: sample was clamped or invalid; qualified by `src_valid`.
- `src_ready` in 1: downstream accept.
- `cnt_clr` in 1: synchronous clear of `sat_count`.
- `sat_count` out CNT_W: saturating count of flagged samples delivered.

## Operation
- Unpack `snk_data` into the sign `s`, the exponent `e` (8 bits) and the mantissa `m` (23 bits). Define `E = e - 127 + SCALE_SHIFT`, signed and 10 bits wide. Define `MAX = 2^OUT_W - 1`.
- Classification is applied in this priority order:
  1. `e==255 && m!=0` (NaN): data 0, sat 1.
  2. `e==255 && m==0` (infinity): `s=0` gives data MAX, sat 1; `s=1` gives data 0, sat 1.
  3. `e==0` (zero or denormal, flushed): data 0, sat 0, both signs.
  4. `s=1` (negative normal): data 0, sat 1.
  5. `E >= OUT_W`: data MAX, sat 1.
  6. `E < -1`: data 0, sat 0. The value is below 0.5.
  7. Otherwise:
     - `g = {1,m} >> (22 - E)`. This is the value times 2, truncated; the shift ranges from 23 down to 23-OUT_W.
     - `r = (g + 1) >> 1`. This rounds half-up; ties go away from zero.
     - If `r > MAX`, data is MAX and sat is 1. Otherwise data is `r` and sat is 0.
- Intermediate `g`/`r` are OUT_W+2 bits wide; no wrap is permitted.
- `sat_count` updates on each output handshake (`src_valid && src_ready`) with `src_sat=1`:
  - It increments by 1 and holds at all-ones; it never wraps.
  - `cnt_clr` sets it to 0 on the next edge.
  - If `cnt_clr` and an increment occur in the same cycle, clear wins and the result is 0.

## Timing
- There are 3 pipeline stages:
  - S1: unpack, classify, compute E.
  - S2: barrel shift to `g`, carry the class code.
  - S3: round, clamp, register `src_data`/`src_sat`.
- Latency is 3 cycles from input handshake to `src_valid`, with no downstream stall.
- Throughput is 1 sample per cycle.
- Flow control uses a global enable: `en = src_ready || !src_valid`.
  - `snk_ready = en`. This is combinational from `src_ready` and registered `src_valid`.
  - When `en=1` all stages advance and stage valids shift: S1 valid takes `snk_valid`.
  - When `en=0` all stage registers, data and valid, hold.
- Bubbles inside the pipeline are not collapsed. Only an empty output register unblocks the pipeline.
- Once asserted, `src_valid` and `src_data`/`src_sat` stay stable until `src_ready` is high.
- Reset (`rst=0` at an edge) has these effects:
  - All stage valids clear and `src_valid=0`.
  - `src_data=0`, `src_sat=0`, `sat_count=0`.
  - `snk_ready` reads 1 in the cycle after reset.
  - In-flight samples are discarded and never emerge.
  - Reset dominates `cnt_clr` and all handshakes.

## Structure
- Shared package `fp_pix_pkg` holds:
  - the float field widths and bias constant (127);
  - the enum `fp_class_t` with values `{FPC_NORM, FPC_ZERO, FPC_NAN, FPC_PINF, FPC_NINF, FPC_NEG}`;
  - the S1→S2 and S2→S3 stage structs.
- A single sub-module, `fp_pix_round_sat`, implements S3 combinational round and clamp. It is reused by the planned fixed-point output path.
- The top level holds the stage registers, the enable logic and `sat_count`.

## Test plan
Unless stated otherwise, cases use OUT_W=8 and SCALE_SHIFT=0.

- Exact and rounding values, with `src_ready=1`:
  - `0x42C80000` (100.0) gives 100.
  - `0x42C90000` (100.5) gives 101.
  - `0x3F000000` (0.5) gives 1.
  - `0x3EFFFFFF` gives 0.
  - `0x437F0000` (255.0) gives 255.
  - All of these have sat 0, and each arrives exactly 3 cycles after its input.
- Clamp cases:
  - `0x437F8000` (255.5) gives 255, sat 1.
  - `0x7F800000` (+Inf) gives 255, sat 1.
  - `0xBF800000` (-1.0) gives 0, sat 1.
  - `0x7FC00000` (NaN) gives 0, sat 1.
  - `0x80000000` (-0) gives 0, sat 0.
  - `0x00000001` (denormal) gives 0, sat 0.
- Backpressure: stream 20 values with random `snk_valid` and random `src_ready`.
  - Output order and values match the model.
  - Nothing is dropped or duplicated.
  - Output is held stable while `src_ready=0`.
- Scaling: with SCALE_SHIFT=8, input `0x3F000000` (0.5) gives 128; input `0x3F800000` (1.0) gives 255, sat 1.
- Counter behaviour:
  - With CNT_W=4, 17 flagged samples leave `sat_count=15`.
  - `cnt_clr` asserted in the same cycle as a flagged handshake gives 0.
- Reset mid-stream: assert `rst=0` with 3 samples in flight.
  - `src_valid` is 0 on the next cycle.
  - No stale sample appears after `rst` returns high.
  - `sat_count=0`.
